// File: rtl/xyz_job_arbiter.sv
// rtl/xyz_job_arbiter.sv - round-robin arbiter sharing one x/y/z datapath among N_REQ requesters
// Latches the winner's operands, pulses dp_start, waits for a dp_done rise or watchdog expiry.
module xyz_job_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] x_in,
  input  logic [N_REQ*DW-1:0] y_in,
  input  logic [N_REQ*DW-1:0] z_in,
  output logic [N_REQ-1:0]    ack,
  output logic                err,
  output logic [N_REQ-1:0]    grant,
  output logic                busy,
  output logic                dp_start,
  output logic [DW-1:0]       dp_x,
  output logic [DW-1:0]       dp_y,
  output logic [DW-1:0]       dp_z,
  input  logic                dp_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RETIRE} state_t;

  state_t            state, state_n;
  logic [N_REQ-1:0]  grant_n, ack_n;
  logic              err_n, dp_start_n;
  logic [IW-1:0]     last, last_n, win, win_n;
  logic [IW-1:0]     pick, cand;
  logic              found;
  logic [DW-1:0]     px, py, pz;
  logic [DW-1:0]     dp_x_n, dp_y_n, dp_z_n;
  logic [WW-1:0]     wdog, wdog_n;
  logic              done_q, done_rise;

  assign done_rise = dp_done & ~done_q;
  assign busy      = (state != S_IDLE);

  // Scan last+1, last+2, ... with wraparound; first requester found wins.
  always_comb begin
    pick  = last;
    cand  = last;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    px = '0;
    py = '0;
    pz = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) begin
        px = x_in[i*DW +: DW];
        py = y_in[i*DW +: DW];
        pz = z_in[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    win_n      = win;
    last_n     = last;
    dp_x_n     = dp_x;
    dp_y_n     = dp_y;
    dp_z_n     = dp_z;
    wdog_n     = wdog;
    dp_start_n = 1'b0;
    ack_n      = '0;
    err_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          win_n         = pick;
          dp_x_n        = px;
          dp_y_n        = py;
          dp_z_n        = pz;
          dp_start_n    = 1'b1;
          state_n       = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wdog_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        wdog_n = wdog + 1'b1;
        // A fresh done edge takes precedence over a simultaneous watchdog expiry.
        if (done_rise) begin
          ack_n   = grant;
          state_n = S_RETIRE;
        end else if (wdog == WW'(TIMEOUT - 1)) begin
          ack_n   = grant;
          err_n   = 1'b1;
          state_n = S_RETIRE;
        end
      end
      S_RETIRE: begin
        last_n  = win;
        grant_n = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      ack      <= '0;
      err      <= 1'b0;
      dp_start <= 1'b0;
      dp_x     <= '0;
      dp_y     <= '0;
      dp_z     <= '0;
      wdog     <= '0;
      done_q   <= 1'b0;
      win      <= '0;
      last     <= IW'(N_REQ - 1);
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      ack      <= ack_n;
      err      <= err_n;
      dp_start <= dp_start_n;
      dp_x     <= dp_x_n;
      dp_y     <= dp_y_n;
      dp_z     <= dp_z_n;
      wdog     <= wdog_n;
      done_q   <= dp_done;
      win      <= win_n;
      last     <= last_n;
    end
  end

endmodule

// File: tb/tb_xyz_job_arbiter.sv
// tb/tb_xyz_job_arbiter.sv - directed self-checking bench for xyz_job_arbiter
module tb_xyz_job_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] x_in, y_in, z_in;
  logic [3:0]  ack, grant;
  logic        err, busy, dp_start, dp_done;
  logic [7:0]  dp_x, dp_y, dp_z;

  int n_checks = 0;
  int n_fail   = 0;

  xyz_job_arbiter #(.N_REQ(4), .DW(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .ack(ack), .err(err), .grant(grant), .busy(busy),
    .dp_start(dp_start), .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
    .dp_done(dp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!dp_start && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_start"}, 32'(dp_start), 32'd1);
    check_eq({tag, "_lat"}, n, exp_n);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    int spurious;

    rst = 1'b1; req = '0; x_in = '0; y_in = '0; z_in = '0; dp_done = 1'b0;
    tick(2);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_start", 32'(dp_start), 32'd0);
    check_eq("rst_dpx", 32'(dp_x), 32'd0);
    rst = 1'b0;

    // single job, done 6 cycles after dp_start
    req = 4'b0001; x_in[7:0] = 8'd5; y_in[7:0] = 8'd71; z_in[7:0] = 8'd81;
    wait_start("t1", 1);
    check_eq("t1_dpx", 32'(dp_x), 32'd5);
    check_eq("t1_dpy", 32'(dp_y), 32'd71);
    check_eq("t1_dpz", 32'(dp_z), 32'd81);
    check_eq("t1_grant", 32'(grant), 32'b0001);
    check_eq("t1_busy", 32'(busy), 32'd1);
    tick();
    check_eq("t1_start_1cyc", 32'(dp_start), 32'd0);
    tick(5);
    check_eq("t1_no_early_ack", 32'(ack), 32'd0);
    dp_done = 1'b1;
    tick();
    check_eq("t1_ack", 32'(ack), 32'b0001);
    check_eq("t1_err", 32'(err), 32'd0);
    dp_done = 1'b0; req = '0;
    tick();
    check_eq("t1_ack_1cyc", 32'(ack), 32'd0);
    check_eq("t1_idle", 32'(busy), 32'd0);

    // round robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    x_in = {8'd4, 8'd3, 8'd2, 8'd1};
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      g = 4'b0001 << (j % 4);
      wait_start($sformatf("t2_j%0d", j), (j == 0) ? 1 : 2);
      check_eq($sformatf("t2_grant_j%0d", j), 32'(grant), 32'(g));
      check_eq($sformatf("t2_dpx_j%0d", j), 32'(dp_x), 32'(j % 4 + 1));
      tick(3);
      dp_done = 1'b1;
      tick();
      check_eq($sformatf("t2_ack_j%0d", j), 32'(ack), 32'(g));
      check_eq($sformatf("t2_err_j%0d", j), 32'(err), 32'd0);
      dp_done = 1'b0;
      if (j == 4) req = '0;
    end

    // sticky done: only a fresh rise completes the job
    tick();
    dp_done = 1'b1; req = 4'b0100;
    wait_start("t3", 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq($sformatf("t3_noearly_c%0d", i), 32'(ack), 32'd0);
      if (i == 4) dp_done = 1'b0;
      if (i == 5) dp_done = 1'b1;
    end
    tick();
    check_eq("t3_ack", 32'(ack), 32'b0100);
    check_eq("t3_err", 32'(err), 32'd0);
    dp_done = 1'b0; req = '0;

    // watchdog expiry, then done coinciding with the last watchdog count
    tick();
    req = 4'b1000;
    wait_start("t4a", 1);
    spurious = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (ack != 4'b0000) spurious++;
    end
    check_eq("t4a_no_early_ack", spurious, 0);
    tick();
    check_eq("t4a_ack", 32'(ack), 32'b1000);
    check_eq("t4a_err", 32'(err), 32'd1);
    req = 4'b0001;
    tick();
    check_eq("t4a_ack_1cyc", 32'(ack), 32'd0);
    check_eq("t4a_err_1cyc", 32'(err), 32'd0);
    wait_start("t4b", 1);
    check_eq("t4b_grant", 32'(grant), 32'b0001);
    tick(16);
    dp_done = 1'b1;
    tick();
    check_eq("t4b_ack", 32'(ack), 32'b0001);
    check_eq("t4b_err", 32'(err), 32'd0);
    dp_done = 1'b0; req = '0;
    tick();

    // reset mid-WAIT and during LAUNCH
    req = 4'b0001;
    wait_start("t5a", 1);
    tick(3);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_grant", 32'(grant), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_dpx", 32'(dp_x), 32'd0);
    check_eq("t5_rst_ack", 32'(ack), 32'd0);
    check_eq("t5_rst_err", 32'(err), 32'd0);
    req = '0;
    tick(2);
    rst = 1'b0; req = 4'b0011;
    wait_start("t5b", 1);
    check_eq("t5_ptr_restored", 32'(grant), 32'b0001);
    rst = 1'b1;
    #1;
    check_eq("t5_async_start", 32'(dp_start), 32'd0);
    tick();
    rst = 1'b0; req = 4'b0010;
    wait_start("t5c", 1);
    check_eq("t5c_grant", 32'(grant), 32'b0010);
    tick(2);
    dp_done = 1'b1;
    tick();
    check_eq("t5c_ack", 32'(ack), 32'b0010);
    dp_done = 1'b0; req = '0;
    tick();

    // operands latched at grant; dropped req still acked
    x_in[23:16] = 8'd5; y_in[23:16] = 8'd6; z_in[23:16] = 8'd7;
    req = 4'b0100;
    wait_start("t6", 1);
    check_eq("t6_dpx_launch", 32'(dp_x), 32'd5);
    tick();
    x_in[23:16] = 8'd200; req = '0;
    tick();
    check_eq("t6_dpx_wait", 32'(dp_x), 32'd5);
    dp_done = 1'b1;
    tick();
    check_eq("t6_ack", 32'(ack), 32'b0100);
    check_eq("t6_dpx_retire", 32'(dp_x), 32'd5);
    check_eq("t6_dpy_retire", 32'(dp_y), 32'd6);
    dp_done = 1'b0;
    tick();
    check_eq("t6_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
